// File: rtl/fpu_arbiter_if.sv
`default_nettype none
// ============================================================================
// fpu_arbiter_if : requester and fpu_top signal bundle for fpu_arbiter
// Revision: 1.0
// ============================================================================
interface fpu_arbiter_if;
  logic        req0_valid;
  logic [4:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ready;
  logic        rsp0_valid;
  logic [31:0] rsp0_data;
  logic        rsp0_err;
  logic        rsp0_ready;

  logic        req1_valid;
  logic [4:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ready;
  logic        rsp1_valid;
  logic [31:0] rsp1_data;
  logic        rsp1_err;
  logic        rsp1_ready;

  logic [9:0]  fpu_opcode;
  logic [31:0] fpu_x1;
  logic [31:0] fpu_x2;
  logic [31:0] fpu_y;
  logic        fpu_out_valid;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    output fpu_opcode, fpu_x1, fpu_x2,
    input  fpu_y, fpu_out_valid
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    input  fpu_opcode, fpu_x1, fpu_x2,
    output fpu_y, fpu_out_valid
  );
endinterface
`default_nettype wire

// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
// fpu_arbiter : two-port round-robin sequencer in front of fpu_top
// Revision: 1.0
// ============================================================================
module fpu_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rstn,
  fpu_arbiter_if.slave bus,
  output logic         busy
);

  localparam int c_CNT_W = $clog2(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  // Map the FP alu_control code onto fpu_top's one-hot opcode; zero means illegal.
  function automatic logic [9:0] f_decode(input logic [4:0] op);
    logic [9:0] v;
    v = '0;
    case (op)
      5'b10000: v[0] = 1'b1;
      5'b10001: v[1] = 1'b1;
      5'b10010: v[2] = 1'b1;
      5'b10011: v[3] = 1'b1;
      5'b11011: v[4] = 1'b1;
      5'b10110: v[5] = 1'b1;
      5'b10111: v[6] = 1'b1;
      5'b10101: v[7] = 1'b1;
      5'b11001: v[8] = 1'b1;
      5'b11000: v[9] = 1'b1;
      default:  v    = '0;
    endcase
    return v;
  endfunction

  logic [1:0]         r_state;
  logic               r_ptr;
  logic               r_owner;
  logic [c_CNT_W-1:0] r_cnt;
  logic [9:0]         r_onehot;
  logic [31:0]        r_x1;
  logic [31:0]        r_x2;
  logic [31:0]        r_data;
  logic               r_err;

  logic        w_idle;
  logic        w_grant;
  logic        w_hs;
  logic [4:0]  w_op;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [9:0]  w_dec;

  // Round-robin pointer only matters when both requesters contend.
  assign w_idle  = rstn && (r_state == c_IDLE);
  assign w_grant = (bus.req0_valid && bus.req1_valid) ? r_ptr : bus.req1_valid;
  assign w_hs    = w_idle && (bus.req0_valid || bus.req1_valid);
  assign w_op    = w_grant ? bus.req1_op : bus.req0_op;
  assign w_a     = w_grant ? bus.req1_a  : bus.req0_a;
  assign w_b     = w_grant ? bus.req1_b  : bus.req0_b;
  assign w_dec   = f_decode(w_op);

  assign bus.req0_ready = w_idle && bus.req0_valid && !w_grant;
  assign bus.req1_ready = w_idle && bus.req1_valid &&  w_grant;

  assign bus.rsp0_valid = (r_state == c_RESP) && !r_owner;
  assign bus.rsp1_valid = (r_state == c_RESP) &&  r_owner;
  assign bus.rsp0_data  = r_data;
  assign bus.rsp1_data  = r_data;
  assign bus.rsp0_err   = r_err;
  assign bus.rsp1_err   = r_err;

  assign bus.fpu_opcode = (r_state == c_ISSUE) ? r_onehot : 10'd0;
  assign bus.fpu_x1     = r_x1;
  assign bus.fpu_x2     = r_x2;
  assign busy           = (r_state != c_IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= c_IDLE;
      r_ptr    <= 1'b0;
      r_owner  <= 1'b0;
      r_cnt    <= '0;
      r_onehot <= '0;
      r_x1     <= '0;
      r_x2     <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_hs) begin
            r_owner  <= w_grant;
            r_onehot <= w_dec;
            r_x1     <= w_a;
            r_x2     <= w_b;
            if (w_dec != 10'd0) begin
              r_state <= c_ISSUE;
            end else begin
              // Illegal op is answered directly without touching the FPU.
              r_data  <= '0;
              r_err   <= 1'b1;
              r_state <= c_RESP;
            end
          end
        end
        c_ISSUE: begin
          r_cnt   <= '0;
          r_state <= c_WAIT;
        end
        c_WAIT: begin
          if (bus.fpu_out_valid) begin
            r_data  <= bus.fpu_y;
            r_err   <= 1'b0;
            r_state <= c_RESP;
          end else if (r_cnt == c_CNT_LAST) begin
            r_data  <= '0;
            r_err   <= 1'b1;
            r_state <= c_RESP;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_RESP: begin
          if (r_owner ? bus.rsp1_ready : bus.rsp0_ready) begin
            r_ptr   <= ~r_owner;
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fpu_arbiter : directed-vector bench for fpu_arbiter (TIMEOUT = 8)
// Revision: 1.0
// ============================================================================
module tb_fpu_arbiter;

  logic clk;
  logic rstn;
  logic busy;
  int   vectors;
  int   miscompares;

  fpu_arbiter_if bus ();

  fpu_arbiter #(.TIMEOUT(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0; bus.rsp0_ready = 0;
    bus.req1_valid = 0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0; bus.rsp1_ready = 0;
    bus.fpu_y = '0; bus.fpu_out_valid = 0;
  endtask

  task automatic drive_req(input bit port, input bit v, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    if (port) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 0;
    step();
    step();
    rstn = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 0;
    step();
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (bus.fpu_opcode !== 10'd0) begin miscompares++; $display("FAIL reset_opcode got=%b exp=0", bus.fpu_opcode); end
    vectors++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%b%b exp=00", bus.rsp0_valid, bus.rsp1_valid); end
    vectors++; if (bus.fpu_x1 !== 32'd0 || bus.fpu_x2 !== 32'd0) begin miscompares++; $display("FAIL reset_operands got=%h/%h exp=0/0", bus.fpu_x1, bus.fpu_x2); end
    vectors++; if (bus.rsp0_data !== 32'd0 || bus.rsp0_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_data got=%h/%b exp=0/0", bus.rsp0_data, bus.rsp0_err); end
    rstn = 1;
    step();
    drive_req(0, 1, 5'b10000, 32'h0, 32'h0);
    vectors++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_idle_grant got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
    drive_req(0, 0, 5'b0, 32'h0, 32'h0);
  endtask

  task automatic test_single();
    drive_req(0, 1, 5'b10000, 32'h3F800000, 32'h40000000);
    vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready got=%b exp=1", bus.req0_ready); end
    step();
    drive_req(0, 0, 5'b0, 32'h0, 32'h0);
    vectors++; if (bus.fpu_opcode !== 10'b0000000001) begin miscompares++; $display("FAIL single_opcode got=%b exp=0000000001", bus.fpu_opcode); end
    vectors++; if (bus.fpu_x1 !== 32'h3F800000 || bus.fpu_x2 !== 32'h40000000) begin miscompares++; $display("FAIL single_operands got=%h/%h exp=3f800000/40000000", bus.fpu_x1, bus.fpu_x2); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b exp=1", busy); end
    step();
    vectors++; if (bus.fpu_opcode !== 10'd0) begin miscompares++; $display("FAIL single_opcode_pulse got=%b exp=0", bus.fpu_opcode); end
    step();
    step();
    step();
    bus.fpu_out_valid = 1; bus.fpu_y = 32'h40400000; #1;
    vectors++; if (bus.rsp0_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_rsp got=%b exp=0", bus.rsp0_valid); end
    step();
    bus.fpu_out_valid = 0; bus.fpu_y = 32'h0; #1;
    vectors++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0) begin miscompares++; $display("FAIL single_rsp_valid got=%b%b exp=10", bus.rsp0_valid, bus.rsp1_valid); end
    vectors++; if (bus.rsp0_data !== 32'h40400000 || bus.rsp0_err !== 1'b0) begin miscompares++; $display("FAIL single_rsp_data got=%h/%b exp=40400000/0", bus.rsp0_data, bus.rsp0_err); end
    bus.rsp0_ready = 1;
    step();
    bus.rsp0_ready = 0; #1;
    vectors++; if (bus.rsp0_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_done got=%b/%b exp=0/0", bus.rsp0_valid, busy); end
  endtask

  task automatic test_contention();
    do_reset();
    step();
    bus.req1_valid = 1; bus.req1_op = 5'b10010; bus.req1_a = 32'd11; bus.req1_b = 32'd22;
    drive_req(0, 1, 5'b10001, 32'd1, 32'd2);
    vectors++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL cont_first_grant got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
    step();
    drive_req(0, 0, 5'b0, 32'h0, 32'h0);
    vectors++; if (bus.fpu_opcode !== 10'b0000000010 || bus.fpu_x1 !== 32'd1) begin miscompares++; $display("FAIL cont_p0_issue got=%b/%h exp=0000000010/1", bus.fpu_opcode, bus.fpu_x1); end
    vectors++; if (bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL cont_loser_ready got=%b exp=0", bus.req1_ready); end
    step();
    bus.fpu_out_valid = 1; bus.fpu_y = 32'hA0A0A0A0;
    step();
    bus.fpu_out_valid = 0;
    // Port 0 comes back with a new op while port 1 still waits.
    drive_req(0, 1, 5'b10011, 32'd3, 32'd4);
    vectors++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp0_data !== 32'hA0A0A0A0) begin miscompares++; $display("FAIL cont_p0_rsp got=%b%b/%h exp=10/a0a0a0a0", bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data); end
    bus.rsp0_ready = 1;
    step();
    bus.rsp0_ready = 0; #1;
    vectors++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin miscompares++; $display("FAIL cont_alternate got=%b%b exp=01", bus.req0_ready, bus.req1_ready); end
    step();
    drive_req(1, 0, 5'b0, 32'h0, 32'h0);
    vectors++; if (bus.fpu_opcode !== 10'b0000000100 || bus.fpu_x1 !== 32'd11 || bus.fpu_x2 !== 32'd22) begin miscompares++; $display("FAIL cont_p1_issue got=%b/%h/%h exp=0000000100/b/16", bus.fpu_opcode, bus.fpu_x1, bus.fpu_x2); end
    step();
    bus.fpu_out_valid = 1; bus.fpu_y = 32'hB0B0B0B0;
    step();
    bus.fpu_out_valid = 0; #1;
    vectors++; if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp1_data !== 32'hB0B0B0B0 || bus.rsp1_err !== 1'b0) begin miscompares++; $display("FAIL cont_p1_rsp got=%b%b/%h/%b exp=01/b0b0b0b0/0", bus.rsp0_valid, bus.rsp1_valid, bus.rsp1_data, bus.rsp1_err); end
    bus.rsp1_ready = 1;
    step();
    bus.rsp1_ready = 0; #1;
    vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL cont_p0_again got=%b exp=1", bus.req0_ready); end
    step();
    drive_req(0, 0, 5'b0, 32'h0, 32'h0);
    vectors++; if (bus.fpu_opcode !== 10'b0000001000) begin miscompares++; $display("FAIL cont_p0_second_issue got=%b exp=0000001000", bus.fpu_opcode); end
    step();
    bus.fpu_out_valid = 1; bus.fpu_y = 32'h1;
    step();
    bus.fpu_out_valid = 0; bus.rsp0_ready = 1;
    step();
    bus.rsp0_ready = 0;
  endtask

  task automatic test_illegal();
    drive_req(1, 1, 5'b10100, 32'd5, 32'd6);
    vectors++; if (bus.req1_ready !== 1'b1) begin miscompares++; $display("FAIL illegal_ready got=%b exp=1", bus.req1_ready); end
    step();
    drive_req(1, 0, 5'b0, 32'h0, 32'h0);
    vectors++; if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0) begin miscompares++; $display("FAIL illegal_rsp_valid got=%b%b exp=01", bus.rsp0_valid, bus.rsp1_valid); end
    vectors++; if (bus.rsp1_data !== 32'd0 || bus.rsp1_err !== 1'b1) begin miscompares++; $display("FAIL illegal_rsp_data got=%h/%b exp=0/1", bus.rsp1_data, bus.rsp1_err); end
    vectors++; if (bus.fpu_opcode !== 10'd0) begin miscompares++; $display("FAIL illegal_opcode got=%b exp=0", bus.fpu_opcode); end
    step();
    vectors++; if (bus.fpu_opcode !== 10'd0 || bus.rsp1_valid !== 1'b1) begin miscompares++; $display("FAIL illegal_hold got=%b/%b exp=0/1", bus.fpu_opcode, bus.rsp1_valid); end
    bus.rsp1_ready = 1;
    step();
    bus.rsp1_ready = 0; #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL illegal_done got=%b exp=0", busy); end
  endtask

  task automatic test_timeout();
    drive_req(0, 1, 5'b11011, 32'd7, 32'd8);
    step();
    drive_req(0, 0, 5'b0, 32'h0, 32'h0);
    vectors++; if (bus.fpu_opcode !== 10'b0000010000) begin miscompares++; $display("FAIL timeout_issue got=%b exp=0000010000", bus.fpu_opcode); end
    step();
    for (int i = 0; i < 7; i++) step();
    vectors++; if (bus.rsp0_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL timeout_early got=%b/%b exp=0/1", bus.rsp0_valid, busy); end
    step();
    vectors++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_err !== 1'b1 || bus.rsp0_data !== 32'd0) begin miscompares++; $display("FAIL timeout_rsp got=%b/%b/%h exp=1/1/0", bus.rsp0_valid, bus.rsp0_err, bus.rsp0_data); end
    bus.fpu_out_valid = 1; bus.fpu_y = 32'h12345678;
    step();
    bus.fpu_out_valid = 0; bus.fpu_y = 32'h0; #1;
    vectors++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_err !== 1'b1 || bus.rsp0_data !== 32'd0) begin miscompares++; $display("FAIL timeout_late_strobe got=%b/%b/%h exp=1/1/0", bus.rsp0_valid, bus.rsp0_err, bus.rsp0_data); end
    bus.rsp0_ready = 1;
    step();
    bus.rsp0_ready = 0;
    bus.fpu_out_valid = 1; bus.fpu_y = 32'h55;
    step();
    bus.fpu_out_valid = 0; #1;
    vectors++; if (busy !== 1'b0 || bus.rsp0_valid !== 1'b0) begin miscompares++; $display("FAIL timeout_idle_strobe got=%b/%b exp=0/0", busy, bus.rsp0_valid); end
  endtask

  task automatic test_backpressure();
    drive_req(0, 1, 5'b10110, 32'd9, 32'd10);
    step();
    drive_req(0, 0, 5'b0, 32'h0, 32'h0);
    step();
    bus.fpu_out_valid = 1; bus.fpu_y = 32'hCAFEBABE;
    step();
    bus.fpu_out_valid = 0;
    bus.req1_valid = 1; bus.req1_op = 5'b10000;
    drive_req(0, 1, 5'b10000, 32'd1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 32'hCAFEBABE || bus.rsp0_err !== 1'b0 ||
          bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold cycle=%0d got=%b/%h/%b rdy=%b%b busy=%b exp=1/cafebabe/0 rdy=00 busy=1",
                 i, bus.rsp0_valid, bus.rsp0_data, bus.rsp0_err, bus.req0_ready, bus.req1_ready, busy);
      end
      step();
    end
    bus.rsp0_ready = 1;
    step();
    bus.rsp0_ready = 0; #1;
    vectors++; if (bus.rsp0_valid !== 1'b0 || bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin miscompares++; $display("FAIL bp_release got=%b rdy=%b%b exp=0 rdy=01", bus.rsp0_valid, bus.req0_ready, bus.req1_ready); end
    bus.req1_valid = 0;
    drive_req(0, 0, 5'b0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    bus.rsp0_ready = 1;
    drive_req(0, 1, 5'b10111, 32'd1, 32'd2);
    step();
    drive_req(0, 1, 5'b10101, 32'd3, 32'd4);
    vectors++; if (bus.fpu_opcode !== 10'b0001000000 || bus.req0_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_issue1 got=%b/%b exp=0001000000/0", bus.fpu_opcode, bus.req0_ready); end
    step();
    bus.fpu_out_valid = 1; bus.fpu_y = 32'h11111111;
    step();
    bus.fpu_out_valid = 0; #1;
    vectors++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 32'h11111111 || bus.req0_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_rsp1 got=%b/%h/%b exp=1/11111111/0", bus.rsp0_valid, bus.rsp0_data, bus.req0_ready); end
    step();
    vectors++; if (bus.rsp0_valid !== 1'b0 || bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_rearm got=%b/%b exp=0/1", bus.rsp0_valid, bus.req0_ready); end
    step();
    drive_req(0, 0, 5'b0, 32'h0, 32'h0);
    // A strobe during ISSUE must not be taken as the result.
    bus.fpu_out_valid = 1; bus.fpu_y = 32'hDEADDEAD; #1;
    vectors++; if (bus.fpu_opcode !== 10'b0010000000 || bus.fpu_x1 !== 32'd3) begin miscompares++; $display("FAIL b2b_issue2 got=%b/%h exp=0010000000/3", bus.fpu_opcode, bus.fpu_x1); end
    step();
    bus.fpu_out_valid = 0; #1;
    vectors++; if (bus.rsp0_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL b2b_stray got=%b/%b exp=0/1", bus.rsp0_valid, busy); end
    bus.fpu_out_valid = 1; bus.fpu_y = 32'h22222222;
    step();
    bus.fpu_out_valid = 0; #1;
    vectors++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 32'h22222222) begin miscompares++; $display("FAIL b2b_rsp2 got=%b/%h exp=1/22222222", bus.rsp0_valid, bus.rsp0_data); end
    step();
    bus.rsp0_ready = 0; #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_done got=%b exp=0", busy); end
  endtask

  task automatic test_decode();
    logic [4:0] ops [10];
    logic [9:0] exp_oh;
    ops = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b11011,
            5'b10110, 5'b10111, 5'b10101, 5'b11001, 5'b11000};
    for (int i = 0; i < 10; i++) begin
      exp_oh = 10'd1 << i;
      drive_req(0, 1, ops[i], 32'(i), 32'(i + 1));
      step();
      drive_req(0, 0, 5'b0, 32'h0, 32'h0);
      vectors++; if (bus.fpu_opcode !== exp_oh) begin miscompares++; $display("FAIL decode op=%b got=%b exp=%b", ops[i], bus.fpu_opcode, exp_oh); end
      step();
      bus.fpu_out_valid = 1; bus.fpu_y = 32'(i);
      step();
      bus.fpu_out_valid = 0; bus.rsp0_ready = 1;
      step();
      bus.rsp0_ready = 0;
    end
  endtask

  task automatic test_reset_mid();
    drive_req(0, 1, 5'b10000, 32'hAAAA5555, 32'h5555AAAA);
    step();
    drive_req(0, 0, 5'b0, 32'h0, 32'h0);
    step();
    step();
    rstn = 0;
    step();
    vectors++; if (busy !== 1'b0 || bus.fpu_opcode !== 10'd0 || bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_ctrl got=%b/%b/%b%b exp=0/0/00", busy, bus.fpu_opcode, bus.rsp0_valid, bus.rsp1_valid); end
    vectors++; if (bus.fpu_x1 !== 32'd0 || bus.fpu_x2 !== 32'd0 || bus.rsp0_data !== 32'd0 || bus.rsp0_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_data got=%h/%h/%h/%b exp=0/0/0/0", bus.fpu_x1, bus.fpu_x2, bus.rsp0_data, bus.rsp0_err); end
    rstn = 1;
    step();
    bus.fpu_out_valid = 1; bus.fpu_y = 32'h77;
    step();
    bus.fpu_out_valid = 0; #1;
    vectors++; if (bus.rsp0_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_stray got=%b/%b exp=0/0", bus.rsp0_valid, busy); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn        = 0;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_illegal();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_decode();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
